// File: rtl/vram_arbiter.sv
// vram_arbiter: sole owner of the single-port 2048x16 colour video RAM.
// Merges scan-out character fetches with byte-wide CPU reads and posted writes.
//
// Ports
//   CLK, RESET_N          clock, asynchronous active-low reset
//   VID_REQ/VID_ADDR      1-cycle fetch strobe and cell address from scan-out
//   VID_DATA              fetched {attr,char}, held until the next fetch returns
//   CPU_ADDR              [ADDR_W]=plane (0 char, 1 attr), [ADDR_W-1:0]=cell
//   CPU_WDATA             write byte
//   CPU_WR/CPU_RD         level requests, held until accepted with CPU_READY
//   CPU_READY             request accepted when (CPU_WR|CPU_RD)&CPU_READY
//   CPU_RDATA/CPU_RVALID  read byte and its 1-cycle return pulse
//   RAM_ADDR/RAM_WDATA    registered RAM address and write data
//   RAM_BE/RAM_WE         registered byte enables ([0]=char) and write strobe
//   RAM_RDATA             RAM read data, one cycle after the address
module vram_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              VID_REQ,
    input  logic [ADDR_W-1:0] VID_ADDR,
    output logic [15:0]       VID_DATA,
    input  logic [ADDR_W:0]   CPU_ADDR,
    input  logic [7:0]        CPU_WDATA,
    input  logic              CPU_WR,
    input  logic              CPU_RD,
    output logic              CPU_READY,
    output logic [7:0]        CPU_RDATA,
    output logic              CPU_RVALID,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [15:0]       RAM_WDATA,
    output logic [1:0]        RAM_BE,
    output logic              RAM_WE,
    input  logic [15:0]       RAM_RDATA
);

    localparam int PW = $clog2(FIFO_DEPTH);
    // FIFO entry: {plane, cell, byte}
    localparam int EW = ADDR_W + 1 + 8;

    localparam logic [1:0] SLOT_IDLE = 2'd0;
    localparam logic [1:0] SLOT_VID  = 2'd1;
    localparam logic [1:0] SLOT_WR   = 2'd2;
    localparam logic [1:0] SLOT_RD   = 2'd3;

    logic [EW-1:0]     fifo_mem [FIFO_DEPTH];
    logic [PW:0]       wr_ptr;
    logic [PW:0]       rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;
    logic [EW-1:0]     head;
    logic              head_plane;
    logic [ADDR_W-1:0] head_addr;
    logic [7:0]        head_data;

    logic              rd_pend;
    logic              rd_issued;
    logic              rd_plane;
    logic [ADDR_W-1:0] rd_addr;

    logic [1:0]        slot;
    logic              wr_acc;
    logic              rd_acc;

    logic              vid_s1;
    logic              vid_s2;
    logic              cpu_s1;
    logic              cpu_s2;

    // Extra pointer MSB separates full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign head       = fifo_mem[rd_ptr[PW-1:0]];
    assign head_plane = head[EW-1];
    assign head_addr  = head[EW-2:8];
    assign head_data  = head[7:0];

    // A pending read blocks everything until its data has been returned,
    // so later writes can never overtake it.
    assign CPU_READY = !fifo_full && !rd_pend;
    assign wr_acc    = CPU_WR && CPU_READY;
    // Simultaneous WR+RD: the write goes first, the read stays requested.
    assign rd_acc    = CPU_RD && !CPU_WR && CPU_READY;

    always_comb begin
        slot = SLOT_IDLE;
        if (VID_REQ) begin
            slot = SLOT_VID;
        end else if (!fifo_empty) begin
            slot = SLOT_WR;
        end else if (rd_pend && !rd_issued) begin
            slot = SLOT_RD;
        end
    end

    // Storage only; emptiness is tracked by the pointers.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            fifo_mem[wr_ptr[PW-1:0]] <= {CPU_ADDR, CPU_WDATA};
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (slot == SLOT_WR) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_pend   <= 1'b0;
            rd_issued <= 1'b0;
            rd_plane  <= 1'b0;
            rd_addr   <= '0;
        end else begin
            if (rd_acc) begin
                rd_pend  <= 1'b1;
                rd_plane <= CPU_ADDR[ADDR_W];
                rd_addr  <= CPU_ADDR[ADDR_W-1:0];
            end
            if (slot == SLOT_RD) begin
                rd_issued <= 1'b1;
            end
            // Held through the return pulse so READY rises the cycle after.
            if (CPU_RVALID) begin
                rd_pend   <= 1'b0;
                rd_issued <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            RAM_ADDR  <= '0;
            RAM_WDATA <= '0;
            RAM_BE    <= '0;
            RAM_WE    <= 1'b0;
        end else begin
            RAM_WE <= 1'b0;
            RAM_BE <= 2'b00;
            unique case (slot)
                SLOT_VID: begin
                    RAM_ADDR <= VID_ADDR;
                end
                SLOT_WR: begin
                    RAM_ADDR  <= head_addr;
                    RAM_WDATA <= {head_data, head_data};
                    RAM_BE    <= head_plane ? 2'b10 : 2'b01;
                    RAM_WE    <= 1'b1;
                end
                SLOT_RD: begin
                    RAM_ADDR <= rd_addr;
                end
                default: begin
                end
            endcase
        end
    end

    // Return pipeline: slot -> address on RAM -> data from RAM -> output.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vid_s1     <= 1'b0;
            vid_s2     <= 1'b0;
            cpu_s1     <= 1'b0;
            cpu_s2     <= 1'b0;
            VID_DATA   <= '0;
            CPU_RDATA  <= '0;
            CPU_RVALID <= 1'b0;
        end else begin
            vid_s1     <= (slot == SLOT_VID);
            vid_s2     <= vid_s1;
            cpu_s1     <= (slot == SLOT_RD);
            cpu_s2     <= cpu_s1;
            CPU_RVALID <= cpu_s2;
            if (vid_s2) begin
                VID_DATA <= RAM_RDATA;
            end
            if (cpu_s2) begin
                CPU_RDATA <= rd_plane ? RAM_RDATA[15:8] : RAM_RDATA[7:0];
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a behavioural RAM.
// Reference memory plus posted-write queue predict every output per cycle.
module tb_vram_arbiter;

    localparam int D = 4;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        VID_REQ = 1'b0;
    logic [10:0] VID_ADDR = '0;
    logic [15:0] VID_DATA;
    logic [11:0] CPU_ADDR = '0;
    logic [7:0]  CPU_WDATA = '0;
    logic        CPU_WR = 1'b0;
    logic        CPU_RD = 1'b0;
    logic        CPU_READY;
    logic [7:0]  CPU_RDATA;
    logic        CPU_RVALID;
    logic [10:0] RAM_ADDR;
    logic [15:0] RAM_WDATA;
    logic [1:0]  RAM_BE;
    logic        RAM_WE;
    logic [15:0] RAM_RDATA;

    always #5 CLK = ~CLK;

    vram_arbiter #(.ADDR_W(11), .FIFO_DEPTH(D)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .VID_REQ(VID_REQ), .VID_ADDR(VID_ADDR), .VID_DATA(VID_DATA),
        .CPU_ADDR(CPU_ADDR), .CPU_WDATA(CPU_WDATA),
        .CPU_WR(CPU_WR), .CPU_RD(CPU_RD), .CPU_READY(CPU_READY),
        .CPU_RDATA(CPU_RDATA), .CPU_RVALID(CPU_RVALID),
        .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_BE(RAM_BE),
        .RAM_WE(RAM_WE), .RAM_RDATA(RAM_RDATA)
    );

    // Behavioural single-port RAM, registered read.
    logic [15:0] ram [2048];
    bit          ram_ready = 1'b0;

    always @(posedge CLK) begin
        if (!ram_ready) begin
            for (int i = 0; i < 2048; i++) ram[i] <= 16'($urandom);
            ram_ready <= 1'b1;
        end else begin
            if (RAM_WE && RAM_BE[0]) ram[RAM_ADDR][7:0]  <= RAM_WDATA[7:0];
            if (RAM_WE && RAM_BE[1]) ram[RAM_ADDR][15:8] <= RAM_WDATA[15:8];
        end
        RAM_RDATA <= ram[RAM_ADDR];
    end

    typedef struct { int due; logic [15:0] val; } exp_t;
    typedef struct packed {
        logic plane; logic [10:0] addr; logic [7:0] data;
    } wr_t;

    logic [15:0] mref [2048];
    wr_t         wq[$];
    exp_t        vq[$];
    exp_t        cq[$];
    bit          m_rd_pend, m_rd_iss, m_rd_plane;
    logic [10:0] m_rd_addr;
    logic [15:0] last_vid = '0;
    logic [7:0]  last_rdata = '0;
    bit          acc_wr, acc_rd;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic model_step();
        bit   rdy, vd, rv;
        wr_t  w;
        logic [15:0] word;
        rdy = (wq.size() < D) && !m_rd_pend;
        check("ready", 32'(CPU_READY), 32'(rdy));
        vd = (vq.size() > 0) && (vq[0].due == cyc);
        if (vd) begin
            last_vid = vq[0].val;
            void'(vq.pop_front());
        end
        check("vid_data", 32'(VID_DATA), 32'(last_vid));
        rv = (cq.size() > 0) && (cq[0].due == cyc);
        check("rvalid", 32'(CPU_RVALID), 32'(rv));
        if (rv) begin
            last_rdata = cq[0].val[7:0];
            void'(cq.pop_front());
        end
        check("rdata", 32'(CPU_RDATA), 32'(last_rdata));
        if (VID_REQ) begin
            vq.push_back('{due: cyc + 3, val: mref[VID_ADDR]});
        end else if (wq.size() > 0) begin
            w = wq.pop_front();
            if (w.plane) mref[w.addr][15:8] = w.data;
            else         mref[w.addr][7:0]  = w.data;
        end else if (m_rd_pend && !m_rd_iss) begin
            m_rd_iss = 1'b1;
            word = mref[m_rd_addr];
            cq.push_back('{due: cyc + 3,
                           val: {8'h00, m_rd_plane ? word[15:8] : word[7:0]}});
        end
        acc_wr = CPU_WR && rdy;
        acc_rd = CPU_RD && !CPU_WR && rdy;
        if (acc_wr) wq.push_back('{plane: CPU_ADDR[11],
                                   addr: CPU_ADDR[10:0], data: CPU_WDATA});
        if (acc_rd) begin
            m_rd_pend  = 1'b1;
            m_rd_plane = CPU_ADDR[11];
            m_rd_addr  = CPU_ADDR[10:0];
        end
        if (rv) begin
            m_rd_pend = 1'b0;
            m_rd_iss  = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge CLK);
        if (RESET_N) model_step();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_vid"},    32'(VID_DATA),   32'h0);
        check({tag, "_rdata"},  32'(CPU_RDATA),  32'h0);
        check({tag, "_rvalid"}, 32'(CPU_RVALID), 32'h0);
        check({tag, "_ready"},  32'(CPU_READY),  32'h1);
        check({tag, "_we"},     32'(RAM_WE),     32'h0);
        check({tag, "_be"},     32'(RAM_BE),     32'h0);
        check({tag, "_addr"},   32'(RAM_ADDR),   32'h0);
    endtask

    task automatic release_reset();
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 2048; i++) mref[i] = ram[i];
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
        bit done = 1'b0;
        CPU_WR = 1'b1; CPU_ADDR = a; CPU_WDATA = d;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (acc_wr) done = 1'b1;
        end
        CPU_WR = 1'b0;
        if (!done) check("wr_timeout", 32'(done), 32'h1);
    endtask

    task automatic cpu_read(input logic [11:0] a);
        bit done = 1'b0;
        CPU_RD = 1'b1; CPU_ADDR = a;
        for (int i = 0; i < 200 && !done; i++) begin
            step();
            if (acc_rd) done = 1'b1;
        end
        CPU_RD = 1'b0;
        for (int i = 0; i < 200 && m_rd_pend; i++) step();
        if (!done || m_rd_pend) check("rd_timeout", 32'(m_rd_pend), 32'h0);
    endtask

    task automatic vid_fetch(input logic [10:0] a);
        VID_REQ = 1'b1; VID_ADDR = a;
        step();
        VID_REQ = 1'b0;
    endtask

    task automatic do_reset();
        #($urandom_range(0, 3));
        RESET_N = 1'b0;
        #1;
        check_reset_vals("t1_rst");
        VID_REQ = 1'b0; CPU_WR = 1'b0; CPU_RD = 1'b0;
        wq.delete(); vq.delete(); cq.delete();
        m_rd_pend = 1'b0; m_rd_iss = 1'b0;
        last_vid = '0; last_rdata = '0;
        repeat ($urandom_range(1, 3)) @(posedge CLK);
        release_reset();
        cpu_read(12'($urandom_range(0, 4095)));
    endtask

    logic [11:0] wa [5];
    logic [7:0]  wd [5];
    logic [15:0] old5;
    int          k, waited, r;

    initial begin
        #1 RESET_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("reset");
        release_reset();

        // T2
        cpu_write(12'h000, 8'h41);
        cpu_write(12'h800, 8'h2E);
        idle(3);
        vid_fetch(11'h000);
        idle(3);
        check("t2_vid", 32'(VID_DATA), 32'h2E41);

        // T3: same-cycle fetch and write, fetch sees the old word
        idle(2);
        old5 = mref[5];
        VID_REQ = 1'b1; VID_ADDR = 11'h005;
        CPU_WR = 1'b1; CPU_ADDR = 12'h005; CPU_WDATA = 8'h7F;
        step();
        check("t3_acc", 32'(acc_wr), 32'h1);
        VID_REQ = 1'b0; CPU_WR = 1'b0;
        idle(4);
        check("t3_old", 32'(VID_DATA), 32'(old5));
        vid_fetch(11'h005);
        idle(4);
        check("t3_new", 32'(VID_DATA[7:0]), 32'h7F);

        // T4: video holds the port, FIFO fills at 4
        wa = '{12'h010, 12'h011, 12'h012, 12'h012, 12'h813};
        wd = '{8'hA0, 8'hA1, 8'hA3, 8'hB4, 8'hC5};
        k = 0;
        for (int i = 0; i < 10; i++) begin
            VID_REQ = 1'b1; VID_ADDR = 11'($urandom);
            CPU_WR = (k < 5); CPU_ADDR = wa[k % 5]; CPU_WDATA = wd[k % 5];
            step();
            if (acc_wr) k++;
        end
        VID_REQ = 1'b0;
        check("t4_accepted", 32'(k), 32'd4);
        waited = 0;
        CPU_WR = 1'b1; CPU_ADDR = wa[4]; CPU_WDATA = wd[4];
        for (int i = 0; i < 20 && k < 5; i++) begin
            step();
            waited++;
            if (acc_wr) k++;
        end
        CPU_WR = 1'b0;
        check("t4_wait", 32'(waited), 32'd2);
        idll_t4: begin
            idle(8);
            vid_fetch(11'h012);
            idle(4);
            check("t4_order", 32'(VID_DATA[7:0]), 32'hB4);
            vid_fetch(11'h013);
            idle(4);
            check("t4_fifth", 32'(VID_DATA[15:8]), 32'hC5);
        end

        // T5: read waits for drain
        cpu_write(12'h123, 8'h55);
        cpu_read(12'h123);
        check("t5_rdata", 32'(CPU_RDATA), 32'h55);
        // WR and RD together: write first, read later sees it
        CPU_WR = 1'b1; CPU_RD = 1'b1; CPU_ADDR = 12'h923; CPU_WDATA = 8'h66;
        for (int i = 0; i < 100 && CPU_RD; i++) begin
            step();
            if (acc_wr) CPU_WR = 1'b0;
            if (acc_rd) CPU_RD = 1'b0;
        end
        CPU_RD = 1'b0;
        for (int i = 0; i < 100 && m_rd_pend; i++) step();
        check("t5_wrrd", 32'(CPU_RDATA), 32'h66);

        // T6 + T1: random traffic with resets dropped in
        for (int i = 0; i < 3000; i++) begin
            if (i == 700 || i == 1900 || $urandom_range(0, 999) == 0) begin
                do_reset();
            end
            VID_REQ  = ($urandom_range(0, 9) < 3) || (i % 500 < 12);
            VID_ADDR = 11'($urandom_range(0, 31));
            if (!CPU_WR && !CPU_RD && $urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 4);
                CPU_ADDR  = {1'($urandom), 11'($urandom_range(0, 31))};
                CPU_WDATA = 8'($urandom);
                CPU_WR    = (r <= 2) || (r == 4);
                CPU_RD    = (r >= 3);
            end
            step();
            if (acc_wr) CPU_WR = 1'b0;
            if (acc_rd) CPU_RD = 1'b0;
        end
        VID_REQ = 1'b0;
        for (int i = 0; i < 200 && (CPU_WR || CPU_RD); i++) begin
            step();
            if (acc_wr) CPU_WR = 1'b0;
            if (acc_rd) CPU_RD = 1'b0;
        end
        CPU_WR = 1'b0; CPU_RD = 1'b0;
        for (int i = 0; i < 50 && (vq.size() + cq.size() + wq.size()) > 0; i++)
            step();
        check("drain", 32'(vq.size() + cq.size() + wq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
